// File: rtl/ss_write_data.sv
// RAM write-side sequencer: on a start edge, streams accepted valid/ready words
// into consecutive RAM addresses from a start index to an inclusive end index.
module ss_write_data #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start_write_data,
  input  logic [SIZE_ADDR-1:0] i_si_ram,
  input  logic [SIZE_ADDR-1:0] i_ei_ram,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_data_valid,
  output logic                 o_ready,
  output logic [SIZE_ADDR-1:0] o_addr_ram,
  output logic [SIZE_DATA-1:0] o_data_ram,
  output logic                 o_we_ram,
  output logic                 o_busy,
  output logic [SIZE_ADDR:0]   o_word_count,
  output logic                 o_done_write_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic                 start_d;
  logic                 start_block;
  logic [SIZE_ADDR-1:0] cur_addr;
  logic [SIZE_ADDR-1:0] end_addr;
  logic                 start_pulse;
  logic                 accept;

  assign start_pulse = i_start_write_data & ~start_d & ~start_block;
  assign accept      = i_data_valid & o_ready;

  // Start edge history; start_block masks a level that was already high during reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      start_d     <= 1'b0;
      start_block <= i_start_write_data;
    end else begin
      start_d     <= i_start_write_data;
      start_block <= start_block & i_start_write_data;
    end
  end

  // Burst sequencer with registered RAM-side and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= IDLE;
      cur_addr          <= '0;
      end_addr          <= '0;
      o_ready           <= 1'b0;
      o_addr_ram        <= '0;
      o_data_ram        <= '0;
      o_we_ram          <= 1'b0;
      o_busy            <= 1'b0;
      o_word_count      <= '0;
      o_done_write_data <= 1'b0;
    end else begin
      o_we_ram          <= 1'b0;
      o_done_write_data <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // The done pulse fires the cycle after the final write, even on a back-to-back restart.
          o_done_write_data <= (state == DONE);
          if (start_pulse) begin
            state        <= WRITE;
            cur_addr     <= i_si_ram;
            end_addr     <= i_ei_ram;
            o_word_count <= '0;
            o_ready      <= 1'b1;
            o_busy       <= 1'b1;
          end else begin
            state   <= IDLE;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        WRITE: begin
          if (accept) begin
            o_we_ram     <= 1'b1;
            o_addr_ram   <= cur_addr;
            o_data_ram   <= i_data;
            o_word_count <= o_word_count + (SIZE_ADDR + 1)'(1);
            cur_addr     <= cur_addr + SIZE_ADDR'(1);
            if (cur_addr == end_addr) begin
              state   <= DONE;
              o_ready <= 1'b0;
              o_busy  <= 1'b0;
            end else begin
              state <= WRITE;
            end
          end else begin
            state <= WRITE;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_write_data.sv
// Directed bench for ss_write_data: table of bursts plus hand-written start and reset sequences.
module tb_ss_write_data;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start_write_data;
  logic [5:0] i_si_ram;
  logic [5:0] i_ei_ram;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       o_ready;
  logic [5:0] o_addr_ram;
  logic [7:0] o_data_ram;
  logic       o_we_ram;
  logic       o_busy;
  logic [6:0] o_word_count;
  logic       o_done_write_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0]  si;
    logic [5:0]  ei;
    int          len;
    logic [15:0] vmask;
    logic [7:0]  seed;
  } vec_t;

  vec_t tbl [6];

  ss_write_data #(.SIZE_ADDR(6), .SIZE_DATA(8)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_start_write_data(i_start_write_data),
    .i_si_ram          (i_si_ram),
    .i_ei_ram          (i_ei_ram),
    .i_data            (i_data),
    .i_data_valid      (i_data_valid),
    .o_ready           (o_ready),
    .o_addr_ram        (o_addr_ram),
    .o_data_ram        (o_data_ram),
    .o_we_ram          (o_we_ram),
    .o_busy            (o_busy),
    .o_word_count      (o_word_count),
    .o_done_write_data (o_done_write_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Runs one burst and checks every cycle against a handshake model.
  // restart_at: loop cycle that pulses a (to be ignored) start; chain_out: restart in the done-state cycle.
  task automatic run_burst(input logic [5:0] si, input logic [5:0] ei, input int len,
                           input logic [15:0] vmask, input logic [7:0] seed,
                           input int restart_at, input bit chain_in, input bit chain_out,
                           input logic [5:0] nsi, input logic [5:0] nei);
    int         acc;
    int         wr;
    int         cyc;
    bit         fin_prev;
    bit         done_seen;
    bit         acc_now;
    logic [5:0] ea;
    acc = 0; wr = 0; cyc = 0; fin_prev = 1'b0; done_seen = 1'b0;
    if (!chain_in) begin
      i_si_ram = si;
      i_ei_ram = ei;
      i_start_write_data = 1'b1;
      tick();
    end
    i_start_write_data = 1'b0;
    while (!done_seen && cyc < 300) begin
      chk("ready", int'(o_ready), int'(acc < len));
      chk("busy", int'(o_busy), int'(acc < len));
      acc_now = vmask[cyc % 16] && (acc < len);
      i_data_valid = vmask[cyc % 16];
      i_data = seed + 8'(acc);
      if (cyc == restart_at) begin
        i_start_write_data = 1'b1;
        i_si_ram = nsi;
        i_ei_ram = nei;
      end else if (cyc == restart_at + 1) begin
        i_start_write_data = 1'b0;
      end
      if (acc_now) acc++;
      tick();
      chk("we", int'(o_we_ram), int'(acc_now));
      if (acc_now) begin
        ea = si + 6'(wr);
        chk("addr", int'(o_addr_ram), int'(ea));
        chk("data", int'(o_data_ram), int'(8'(seed + 8'(wr))));
        wr++;
      end
      chk("count", int'(o_word_count), (fin_prev && chain_out) ? 0 : wr);
      chk("done", int'(o_done_write_data), int'(fin_prev));
      done_seen = fin_prev;
      fin_prev = acc_now && (acc == len);
      if (fin_prev && chain_out) begin
        i_si_ram = nsi;
        i_ei_ram = nei;
        i_start_write_data = 1'b1;
      end
      cyc++;
    end
    i_data_valid = 1'b0;
    if (!done_seen) chk("timeout", 0, 1);
  endtask

  initial begin
    tbl[0] = '{6'd3,  6'd6,  4,  16'hFFFF, 8'hA0};
    tbl[1] = '{6'd10, 6'd10, 1,  16'hFFFF, 8'hD0};
    tbl[2] = '{6'd62, 6'd1,  4,  16'hFFFF, 8'h30};
    tbl[3] = '{6'd0,  6'd63, 64, 16'hFFFF, 8'h00};
    tbl[4] = '{6'd20, 6'd23, 4,  16'hFFD9, 8'h50};
    tbl[5] = '{6'd40, 6'd45, 6,  16'h5555, 8'h77};

    // Reset with start held high: no burst may follow reset release.
    i_rst = 1'b1;
    i_start_write_data = 1'b1;
    i_si_ram = 6'd5;
    i_ei_ram = 6'd9;
    i_data = 8'h00;
    i_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_addr", int'(o_addr_ram), 0);
    chk("rst_data", int'(o_data_ram), 0);
    chk("rst_we", int'(o_we_ram), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_count", int'(o_word_count), 0);
    chk("rst_done", int'(o_done_write_data), 0);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_busy", int'(o_busy), 0);
      chk("held_ready", int'(o_ready), 0);
    end
    i_start_write_data = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      run_burst(tbl[t].si, tbl[t].ei, tbl[t].len, tbl[t].vmask, tbl[t].seed,
                -1, 1'b0, 1'b0, 6'd0, 6'd0);
      chk("post_ready", int'(o_ready), 0);
      chk("post_count", int'(o_word_count), tbl[t].len);
    end

    // Start edge mid-burst is ignored; the original 5-word range completes.
    run_burst(6'd30, 6'd34, 5, 16'hFFFF, 8'h60, 2, 1'b0, 1'b0, 6'd50, 6'd51);
    tick();
    chk("restart_idle", int'(o_busy), 0);

    // Start edge in the done-state cycle chains straight into a second burst.
    run_burst(6'd12, 6'd13, 2, 16'hFFFF, 8'h90, -1, 1'b0, 1'b1, 6'd14, 6'd16);
    run_burst(6'd14, 6'd16, 3, 16'hFFFF, 8'hB0, -1, 1'b1, 1'b0, 6'd0, 6'd0);
    chk("chain_count", int'(o_word_count), 3);

    // Reset after 2 of 5 writes aborts the burst without a done pulse.
    i_si_ram = 6'd8;
    i_ei_ram = 6'd12;
    i_start_write_data = 1'b1;
    tick();
    i_start_write_data = 1'b0;
    i_data_valid = 1'b1;
    i_data = 8'h11;
    tick();
    chk("ab_we1", int'(o_we_ram), 1);
    chk("ab_addr1", int'(o_addr_ram), 8);
    i_data = 8'h12;
    tick();
    chk("ab_we2", int'(o_we_ram), 1);
    chk("ab_addr2", int'(o_addr_ram), 9);
    chk("ab_count2", int'(o_word_count), 2);
    i_rst = 1'b1;
    i_data = 8'h13;
    tick();
    i_rst = 1'b0;
    chk("ab_we", int'(o_we_ram), 0);
    chk("ab_addr", int'(o_addr_ram), 0);
    chk("ab_data", int'(o_data_ram), 0);
    chk("ab_ready", int'(o_ready), 0);
    chk("ab_busy", int'(o_busy), 0);
    chk("ab_count", int'(o_word_count), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ab_no_we", int'(o_we_ram), 0);
      chk("ab_no_done", int'(o_done_write_data), 0);
    end
    i_data_valid = 1'b0;
    tick();

    run_burst(6'd8, 6'd12, 5, 16'hFFFF, 8'hC0, -1, 1'b0, 1'b0, 6'd0, 6'd0);
    chk("fresh_count", int'(o_word_count), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
